// File: rtl/translate.sv
// ---------------------------------------------------------------------------
// translate
//   Registered decode of the RVV vtype fields vsew/vlmul into an element
//   width in bits, an LMUL magnitude with a fractional flag, a legality flag
//   and VLMAX = VLEN*LMUL/SEW. The decode is done in the log2 domain, so
//   VLMAX needs only a single shift and no divider.
//
// Parameters
//   VLEN  vector register length in bits (power of two, >= ELEN)
//   ELEN  max element width in bits (8/16/32/64)
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   SEW_encoded   in   [2:0] vsew field
//   lmul_encoded  in   [2:0] vlmul field
//   SEW           out  [7:0] element width in bits, 0 if illegal
//   lmul          out  [4:0] {fractional, 1/2/4/8}, 0 if illegal
//   vlmax         out  [$clog2(VLEN):0] VLEN*LMUL/SEW, 0 if illegal
//   valid         out  encoding pair legal for this configuration
// ---------------------------------------------------------------------------
module translate #(
  parameter int VLEN = 128,
  parameter int ELEN = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              SEW_encoded,
  input  logic [2:0]              lmul_encoded,
  output logic [7:0]              SEW,
  output logic [4:0]              lmul,
  output logic [$clog2(VLEN):0]   vlmax,
  output logic                    valid
);

  localparam int VW = $clog2(VLEN) + 1;
  localparam logic [7:0] LOG_VLEN = 8'($clog2(VLEN));
  localparam logic [3:0] LOG_ELEN = 4'($clog2(ELEN));

  logic          frac;
  logic [1:0]    d_log;     // log2 of the fractional divisor
  logic [1:0]    m_log;     // log2 of the integer multiplier
  logic [3:0]    sew_log;   // log2(SEW) = 3 + vsew
  logic [7:0]    sh;        // log2(VLMAX)
  logic          ok;
  logic [7:0]    sew_d;
  logic [4:0]    lmul_d;
  logic [VW-1:0] vlmax_d;

  always_comb begin
    frac    = lmul_encoded[2];
    // 111->1, 110->2, 101->3 is the two's complement of the low bits
    d_log   = 2'(~lmul_encoded[1:0] + 2'd1);
    m_log   = frac ? 2'd0 : lmul_encoded[1:0];
    sew_log = {2'b00, SEW_encoded[1:0]} + 4'd3;

    ok = !SEW_encoded[2] && (sew_log <= LOG_ELEN) && (lmul_encoded != 3'b100);
    if (frac && (sew_log + {2'b00, d_log} > LOG_ELEN))
      ok = 1'b0;

    // Legal pairs always give sh >= log2(VLEN/ELEN) >= 0, so the unsigned
    // intermediate can only wrap for encodings that are masked off anyway.
    sh = LOG_VLEN + {6'd0, m_log} - (frac ? {6'd0, d_log} : 8'd0) - {4'd0, sew_log};

    sew_d   = 8'd0;
    lmul_d  = 5'd0;
    vlmax_d = '0;
    if (ok) begin
      sew_d   = 8'd8 << SEW_encoded[1:0];
      lmul_d  = {frac, 4'b0001 << (frac ? d_log : m_log)};
      vlmax_d = VW'(1) << sh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      SEW   <= 8'd0;
      lmul  <= 5'd0;
      vlmax <= '0;
      valid <= 1'b0;
    end else begin
      SEW   <= sew_d;
      lmul  <= lmul_d;
      vlmax <= vlmax_d;
      valid <= ok;
    end
  end

endmodule

// File: tb/tb_translate.sv
module tb_translate;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] se, lm, se2, lm2;
  logic [7:0] sew, sew2;
  logic [4:0] lmul, lmul2;
  logic [7:0] vlmax, vlmax2;
  logic       valid, valid2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  translate #(.VLEN(128), .ELEN(64)) dut (
    .clk(clk), .rst(rst), .SEW_encoded(se), .lmul_encoded(lm),
    .SEW(sew), .lmul(lmul), .vlmax(vlmax), .valid(valid)
  );

  translate #(.VLEN(128), .ELEN(32)) dut32 (
    .clk(clk), .rst(rst), .SEW_encoded(se2), .lmul_encoded(lm2),
    .SEW(sew2), .lmul(lmul2), .vlmax(vlmax2), .valid(valid2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect64(input string tag, input logic [7:0] es, input logic [4:0] el,
                          input logic [7:0] ev, input logic evd);
    check({tag, ".sew"},   32'(sew),   32'(es));
    check({tag, ".lmul"},  32'(lmul),  32'(el));
    check({tag, ".vlmax"}, 32'(vlmax), 32'(ev));
    check({tag, ".valid"}, 32'(valid), 32'(evd));
  endtask

  task automatic expect32(input string tag, input logic [7:0] es, input logic [4:0] el,
                          input logic [7:0] ev, input logic evd);
    check({tag, ".sew"},   32'(sew2),   32'(es));
    check({tag, ".lmul"},  32'(lmul2),  32'(el));
    check({tag, ".vlmax"}, 32'(vlmax2), 32'(ev));
    check({tag, ".valid"}, 32'(valid2), 32'(evd));
  endtask

  // Apply on the falling edge, sample on the falling edge after the next rise.
  task automatic v64(input string tag, input logic [2:0] s, input logic [2:0] l,
                     input logic [7:0] es, input logic [4:0] el,
                     input logic [7:0] ev, input logic evd);
    se = s; lm = l;
    @(posedge clk); @(negedge clk);
    expect64(tag, es, el, ev, evd);
  endtask

  task automatic v32(input string tag, input logic [2:0] s, input logic [2:0] l,
                     input logic [7:0] es, input logic [4:0] el,
                     input logic [7:0] ev, input logic evd);
    se2 = s; lm2 = l;
    @(posedge clk); @(negedge clk);
    expect32(tag, es, el, ev, evd);
  endtask

  initial begin
    rst = 1'b1; se = 3'b000; lm = 3'b011; se2 = 3'b010; lm2 = 3'b000;
    @(posedge clk); @(negedge clk);
    expect64("rst", 8'd0, 5'd0, 8'd0, 1'b0);
    expect32("rst32", 8'd0, 5'd0, 8'd0, 1'b0);
    @(posedge clk); @(negedge clk);
    expect64("rst_hold", 8'd0, 5'd0, 8'd0, 1'b0);
    rst = 1'b0;
    #1 expect64("pre_edge", 8'd0, 5'd0, 8'd0, 1'b0);
    @(posedge clk); @(negedge clk);
    expect64("post_rst", 8'd8, 5'h08, 8'd128, 1'b1);
    expect32("post_rst32", 8'd32, 5'h01, 8'd4, 1'b1);

    // reserved / illegal pairs
    v64("r111_111", 3'b111, 3'b111, 0, 0, 0, 0);
    v64("r101_100", 3'b101, 3'b100, 0, 0, 0, 0);
    v64("r100_101", 3'b100, 3'b101, 0, 0, 0, 0);
    v64("r100_100", 3'b100, 3'b100, 0, 0, 0, 0);
    v64("r010_100", 3'b010, 3'b100, 0, 0, 0, 0);
    // integer LMUL
    v64("i000_010", 3'b000, 3'b010, 8'd8,  5'h04, 8'd64,  1);
    v64("i011_011", 3'b011, 3'b011, 8'd64, 5'h08, 8'd16,  1);
    v64("i000_000", 3'b000, 3'b000, 8'd8,  5'h01, 8'd16,  1);
    v64("i001_001", 3'b001, 3'b001, 8'd16, 5'h02, 8'd16,  1);
    v64("i000_011", 3'b000, 3'b011, 8'd8,  5'h08, 8'd128, 1);
    // fractional LMUL
    v64("f000_101", 3'b000, 3'b101, 8'd8,  5'h18, 8'd2, 1);
    v64("f010_111", 3'b010, 3'b111, 8'd32, 5'h12, 8'd2, 1);
    v64("f001_110", 3'b001, 3'b110, 8'd16, 5'h14, 8'd2, 1);
    v64("f011_111", 3'b011, 3'b111, 0, 0, 0, 0);
    v64("f010_110", 3'b010, 3'b110, 0, 0, 0, 0);
    v64("f011_101", 3'b011, 3'b101, 0, 0, 0, 0);

    // ELEN=32 build
    v32("e32_011_000", 3'b011, 3'b000, 0, 0, 0, 0);
    v32("e32_010_000", 3'b010, 3'b000, 8'd32, 5'h01, 8'd4, 1);
    v32("e32_001_111", 3'b001, 3'b111, 8'd16, 5'h12, 8'd4, 1);
    v32("e32_010_111", 3'b010, 3'b111, 0, 0, 0, 0);

    // back-to-back changes: outputs hold the previous result until the edge
    se = 3'b000; lm = 3'b001;
    @(posedge clk); @(negedge clk);
    expect64("tog0", 8'd8, 5'h02, 8'd32, 1);
    se = 3'b011; lm = 3'b000;
    #1 expect64("tog1_hold", 8'd8, 5'h02, 8'd32, 1);
    @(posedge clk); @(negedge clk);
    expect64("tog1", 8'd64, 5'h01, 8'd2, 1);
    se = 3'b110; lm = 3'b000;
    #1 expect64("tog2_hold", 8'd64, 5'h01, 8'd2, 1);
    @(posedge clk); @(negedge clk);
    expect64("tog2", 0, 0, 0, 0);
    se = 3'b001; lm = 3'b010;
    @(posedge clk); @(negedge clk);
    expect64("tog3", 8'd16, 5'h04, 8'd32, 1);

    // reset wins over legal inputs mid-stream
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    expect64("rst_mid", 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    expect64("rst_mid_rel", 8'd16, 5'h04, 8'd32, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
